// File: rtl/msp430_dbg_i2c_master.sv
// Single-byte I2C master for the debug port.
// Each accepted command runs one frame: START, address+R/W, address ACK,
// one data byte (write or read), ACK slot, STOP, then a one-cycle response.
// Ports:
//   mclk, puc_rst            clock and synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_rd/cmd_addr/cmd_data command fields, captured on accept
//   rsp_valid/rsp_data/rsp_nack  completion pulse, read byte, NACK flag
//   scl_out/sda_out          line drives (1 = released)
//   sda_in                   synchronised SDA line
module msp430_dbg_i2c_master #(
    parameter int unsigned DIV = 4
) (
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       scl_out,
    output logic       sda_out,
    input  logic       sda_in
);

    localparam int unsigned QW    = $clog2(DIV + 1);
    localparam logic [QW-1:0] QLAST = QW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          rd_q, rd_n;
    logic [7:0]    abyte_q, abyte_n;
    logic [7:0]    dbyte_q, dbyte_n;
    logic [7:0]    rx_q, rx_n;
    logic          nack_q, nack_n;
    logic          scl_n, sda_n;
    logic [7:0]    rsp_data_n;
    logic          rsp_nack_n;
    logic          q_end, slot_end, sample;

    // Quarter-phase timing strobes
    assign q_end    = (qcnt == QLAST);
    assign slot_end = q_end && (phase == 2'd3);
    assign sample   = q_end && (phase == 2'd2);

    // Next-state, datapath and next-output logic
    always_comb begin
        state_n    = state;
        qcnt_n     = q_end ? '0 : qcnt + 1'b1;
        phase_n    = q_end ? phase + 2'd1 : phase;
        bit_cnt_n  = bit_cnt;
        rd_n       = rd_q;
        abyte_n    = abyte_q;
        dbyte_n    = dbyte_q;
        rx_n       = rx_q;
        nack_n     = nack_q;
        rsp_data_n = rsp_data;
        rsp_nack_n = rsp_nack;
        scl_n      = 1'b1;
        sda_n      = 1'b1;

        case (state)
            IDLE: begin
                qcnt_n    = '0;
                phase_n   = '0;
                bit_cnt_n = '0;
                if (cmd_valid) begin
                    state_n = START;
                    rd_n    = cmd_rd;
                    abyte_n = {cmd_addr, cmd_rd};
                    dbyte_n = cmd_data;
                    rx_n    = '0;
                    nack_n  = 1'b0;
                end
            end
            // START occupies two quarters, then bit slots restart at Q0
            START: begin
                if (q_end && (phase == 2'd1)) begin
                    state_n = ADDR;
                    phase_n = '0;
                end
            end
            ADDR: begin
                if (slot_end) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = AACK;
                end
            end
            // nack_q is already updated from the Q2 sample by the slot end
            AACK: begin
                if (sample) nack_n = sda_in;
                if (slot_end) state_n = nack_q ? STOP : DATA;
            end
            DATA: begin
                if (sample && rd_q) rx_n = {rx_q[6:0], sda_in};
                if (slot_end) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = DACK;
                end
            end
            // On reads the master NACKs the only byte; that is not an error
            DACK: begin
                if (sample && !rd_q) nack_n = sda_in;
                if (slot_end) state_n = STOP;
            end
            STOP: begin
                if (slot_end) begin
                    state_n    = DONE;
                    rsp_data_n = rx_q;
                    rsp_nack_n = nack_q;
                end
            end
            DONE: begin
                state_n = IDLE;
                qcnt_n  = '0;
                phase_n = '0;
            end
            default: state_n = IDLE;
        endcase

        // Line levels follow the upcoming state so the registered outputs line up with it
        case (state_n)
            START: sda_n = 1'b0;
            ADDR: begin
                scl_n = phase_n[1];
                sda_n = abyte_n[3'd7 - bit_cnt_n];
            end
            AACK, DACK: scl_n = phase_n[1];
            DATA: begin
                scl_n = phase_n[1];
                sda_n = rd_n | dbyte_n[3'd7 - bit_cnt_n];
            end
            STOP: begin
                scl_n = phase_n[1];
                sda_n = (phase_n == 2'd3);
            end
            default: ;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            rd_q      <= 1'b0;
            abyte_q   <= '0;
            dbyte_q   <= '0;
            rx_q      <= '0;
            nack_q    <= 1'b0;
            scl_out   <= 1'b1;
            sda_out   <= 1'b1;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            rd_q      <= rd_n;
            abyte_q   <= abyte_n;
            dbyte_q   <= dbyte_n;
            rx_q      <= rx_n;
            nack_q    <= nack_n;
            scl_out   <= scl_n;
            sda_out   <= sda_n;
            cmd_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == DONE);
            rsp_data  <= rsp_data_n;
            rsp_nack  <= rsp_nack_n;
        end
    end

endmodule
